// File: rtl/ram_burst_reader.sv
// Burst read controller for a 2^ADDR_W x DATA_W synchronous-read RAM.
// The one-cycle read latency is absorbed by a 2-entry FIFO with credit-gated read issue.
module ram_burst_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 5
) (
  input  logic              r_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              r_en,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] r_data,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr_cnt;
  logic [LEN_W-1:0]  r_issue_rem;
  logic [LEN_W-1:0]  r_out_rem;
  logic              r_inflight;
  logic              r_done;
  logic [DATA_W-1:0] r_fifo [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  logic              w_pop;
  logic [2:0]        w_occ;
  logic              w_credit;

  // A pop this cycle frees a slot, so it counts toward the credit for a new read.
  assign w_pop    = dout_valid && dout_ready;
  assign w_occ    = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_credit = w_occ < (3'd2 + {2'b00, w_pop});

  assign r_en       = (r_state == RUN) && (r_issue_rem != {LEN_W{1'b0}}) && w_credit;
  assign r_addr     = r_addr_cnt;
  assign busy       = (r_state == RUN);
  assign done       = r_done;
  assign dout_valid = (r_count != 2'd0);
  assign dout       = dout_valid ? r_fifo[r_rd_ptr] : {DATA_W{1'b0}};
  assign dout_last  = dout_valid && (r_out_rem == LEN_W'(1'b1));

  // Burst FSM, read issue counters, in-flight tracking and output FIFO.
  always_ff @(posedge r_clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr_cnt  <= {ADDR_W{1'b0}};
      r_issue_rem <= {LEN_W{1'b0}};
      r_out_rem   <= {LEN_W{1'b0}};
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
      r_fifo[0]   <= {DATA_W{1'b0}};
      r_fifo[1]   <= {DATA_W{1'b0}};
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= r_en;
      if (r_inflight) begin
        r_fifo[r_wr_ptr] <= r_data;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
      if (r_en) begin
        r_addr_cnt  <= r_addr_cnt + ADDR_W'(1'b1);
        r_issue_rem <= r_issue_rem - LEN_W'(1'b1);
      end
      case (r_state)
        IDLE: begin
          if (start && (len != {LEN_W{1'b0}})) begin
            r_addr_cnt  <= start_addr;
            r_issue_rem <= len;
            r_out_rem   <= len;
            r_state     <= RUN;
          end
        end
        RUN: begin
          if (w_pop) begin
            r_out_rem <= r_out_rem - LEN_W'(1'b1);
            if (r_out_rem == LEN_W'(1'b1)) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
